sc_bitstream_readback: RTL and testbench
========================================

Name: sc_bitstream_readback

Overview:
Captures the bitstream shifted out of the scan-chain tail and stores it for host readout. It is the receiving end of the chain driven by the scan-chain bitstream loader. It samples one bit per enabled cycle, packs bits LSB-first into words in an internal buffer, and compares each bit against an expected stream. It reports a mismatch count for configuration-integrity checks.

Parameters:
BITSTREAM_SIZE, 721, number of chain bits captured per run (≥1)
WORD_WIDTH, 16, bits per buffer word
NUM_WORDS, ceil(BITSTREAM_SIZE/WORD_WIDTH) (derived localparam, 46 by default), buffer depth
AW, max(1,$clog2(NUM_WORDS)) (derived), buffer address width
CW, $clog2(BITSTREAM_SIZE+1) (derived), bit counter / mismatch counter width

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  run request, sampled in IDLE or DONE only
chain_tail  input  1  scan-chain output bit
exp_bit  input  1  expected value of current bit, valid same cycle as chain_tail
shift_en  output  1  chain shift enable; high exactly BITSTREAM_SIZE cycles per run
bit_index  output  CW  index of bit being sampled this cycle (drives expected-bit ROM)
busy  output  1  high in SHIFT and FLUSH
done  output  1  high in DONE
mismatch_count  output  CW  number of bits where chain_tail != exp_bit in last run
rd_addr  input  AW  host read address
rd_data  output  WORD_WIDTH  buffer word at rd_addr, registered

Behaviour:
- Reset (async assert, sync deassert internally assumed by board): state=IDLE, shift_en=0, bit_index=0, busy=0, done=0, mismatch_count=0, rd_data=0, pack register=0, word pointer=0. Buffer contents are not cleared.
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE/DONE + start=1 -> SHIFT next edge: bit_index=0, mismatch_count=0, pack reg=0, word ptr=0, done=0.
- SHIFT: shift_en=1 combinationally from state. Each edge: pack[bit_index mod WORD_WIDTH] <= chain_tail; mismatch_count += (chain_tail ^ exp_bit); bit_index++.
- The bit at bit_index=k is the k-th bit leaving the chain. Bit 0 is the first sample after entering SHIFT.
- Word write: on the edge sampling bit (WORD_WIDTH-1) mod WORD_WIDTH, the completed word (including the bit just sampled) is written to buffer[word ptr]. Word ptr then increments and pack clears.
- Last sample edge (bit_index==BITSTREAM_SIZE-1) -> FLUSH. If the final word is partial, FLUSH writes it with unused upper bits = 0. If it is full, it was already written and FLUSH writes nothing. FLUSH lasts 1 cycle -> DONE.
- DONE holds until start or reset. bit_index holds BITSTREAM_SIZE-1 in FLUSH and DONE. mismatch_count is stable from the FLUSH entry edge.
- start during SHIFT/FLUSH is ignored. start held high in DONE begins a new run immediately, giving back-to-back runs with 2 idle cycles (FLUSH, DONE) between shift windows.
- mismatch_count saturates at BITSTREAM_SIZE (cannot exceed by construction; no wrap).
- Read port: rd_data <= buffer[rd_addr] every edge, 1-cycle latency, independent of state.
  - rd_addr ≥ NUM_WORDS returns 0.
  - A read to the address written on the same edge returns the old data (read-first).
- Reset mid-run: immediate return to IDLE and shift_en=0. Buffer holds any words written so far. done stays 0 until a full run completes.
- Buffer is inferred RAM (NUM_WORDS × WORD_WIDTH); no primitive instantiation required.

Test Plan:
- Reset then single start pulse, chain_tail = alternating 1,0,... starting 1, exp_bit = same -> shift_en high exactly 721 cycles. Words 0..44 = 16'h5555, word 45 = 16'h0001, mismatch_count=0, done asserted 2 cycles after last shift cycle.
- Same run with exp_bit tied 0, chain_tail = 1 for bits 0..63 only -> words 0..3 = 16'hFFFF, rest 0, mismatch_count=64.
- Override BITSTREAM_SIZE=32, WORD_WIDTH=16, chain_tail=1 always -> words 0,1 = 16'hFFFF, FLUSH writes nothing, word count written = 2, done after 32+1 cycles.
- Assert rst_n=0 at bit_index=300 -> shift_en=0 and busy=0 same cycle. Words 0..17 retain new data, done=0. A new start then produces a full 721-bit run.
- Pulse start at bit 100 of a run and again in DONE with start held high -> first pulse ignored (bit_index continues). Second gives back-to-back run, mismatch_count cleared to 0 at new SHIFT entry.
- Read rd_addr=0..45 and 50 after a run -> data 1 cycle after address; addr 50 returns 16'h0000.

Source files
------------

// File: rtl/sc_bitstream_readback_if.sv
// Host/chain-side signal bundle for the scan-chain bitstream readback block.
// The slave modport is the readback block; the master modport is whoever drives the chain and host.
interface sc_bitstream_readback_if #(
  parameter int unsigned BITSTREAM_SIZE = 721,
  parameter int unsigned WORD_WIDTH     = 16
);
  localparam int unsigned NUM_WORDS = (BITSTREAM_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CW        = $clog2(BITSTREAM_SIZE + 1);

  logic                  start;
  logic                  chain_tail;
  logic                  exp_bit;
  logic                  shift_en;
  logic [CW-1:0]         bit_index;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         mismatch_count;
  logic [AW-1:0]         rd_addr;
  logic [WORD_WIDTH-1:0] rd_data;

  modport master (
    output start, chain_tail, exp_bit, rd_addr,
    input  shift_en, bit_index, busy, done, mismatch_count, rd_data
  );

  modport slave (
    input  start, chain_tail, exp_bit, rd_addr,
    output shift_en, bit_index, busy, done, mismatch_count, rd_data
  );
endinterface

// File: rtl/sc_bitstream_readback.sv
// Captures the scan-chain tail bit by bit, packs it LSB-first into a word buffer for host
// readout and counts bits that differ from the expected stream.
module sc_bitstream_readback #(
  parameter int unsigned BITSTREAM_SIZE = 721,
  parameter int unsigned WORD_WIDTH     = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  sc_bitstream_readback_if.slave bus
);
  localparam int unsigned NUM_WORDS = (BITSTREAM_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CW        = $clog2(BITSTREAM_SIZE + 1);
  localparam int unsigned PW        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CW-1:0] LastBit  = CW'(BITSTREAM_SIZE - 1);
  localparam logic [CW-1:0] MaxCount = CW'(BITSTREAM_SIZE);
  localparam logic [PW-1:0] LastPos  = PW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFlush, StDone} state_e;

  state_e                r_state;
  logic [CW-1:0]         r_bit_index;
  logic [CW-1:0]         r_mismatch;
  logic [PW-1:0]         r_bit_pos;
  logic [WORD_WIDTH-1:0] r_pack;
  logic [AW-1:0]         r_wptr;
  logic [WORD_WIDTH-1:0] r_rd_data;
  logic [WORD_WIDTH-1:0] r_mem [NUM_WORDS];

  logic [WORD_WIDTH-1:0] w_pack_next;
  logic [WORD_WIDTH-1:0] w_wdata;
  logic                  w_we;
  logic                  w_word_full;
  logic                  w_miss;

  always_comb begin
    w_pack_next            = r_pack;
    w_pack_next[r_bit_pos] = bus.chain_tail;
  end

  assign w_word_full = (r_bit_pos == LastPos);
  assign w_miss      = bus.chain_tail ^ bus.exp_bit;

  // A full word is stored on the edge that samples its top bit; FLUSH only stores a partial tail.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = w_pack_next;
    if (r_state == StShift) begin
      w_we = w_word_full;
    end else if ((r_state == StFlush) && (r_bit_pos != '0)) begin
      w_we    = 1'b1;
      w_wdata = r_pack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bit_index <= '0;
      r_mismatch  <= '0;
      r_bit_pos   <= '0;
      r_pack      <= '0;
      r_wptr      <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            r_state     <= StShift;
            r_bit_index <= '0;
            r_mismatch  <= '0;
            r_bit_pos   <= '0;
            r_pack      <= '0;
            r_wptr      <= '0;
          end
        end
        StShift: begin
          if (w_miss && (r_mismatch != MaxCount)) begin
            r_mismatch <= r_mismatch + 1'b1;
          end
          if (w_word_full) begin
            r_pack    <= '0;
            r_bit_pos <= '0;
            r_wptr    <= r_wptr + 1'b1;
          end else begin
            r_pack    <= w_pack_next;
            r_bit_pos <= r_bit_pos + 1'b1;
          end
          // bit_index parks on the last bit through FLUSH and DONE.
          if (r_bit_index == LastBit) begin
            r_state <= StFlush;
          end else begin
            r_bit_index <= r_bit_index + 1'b1;
          end
        end
        StFlush: r_state <= StDone;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  // Read-first: a same-edge write is not visible until the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (32'(bus.rd_addr) < NUM_WORDS) begin
      r_rd_data <= r_mem[bus.rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign bus.shift_en       = (r_state == StShift);
  assign bus.busy           = (r_state == StShift) || (r_state == StFlush);
  assign bus.done           = (r_state == StDone);
  assign bus.bit_index      = r_bit_index;
  assign bus.mismatch_count = r_mismatch;
  assign bus.rd_data        = r_rd_data;
endmodule

// File: tb/tb_sc_bitstream_readback.sv
// Directed bench for sc_bitstream_readback: default 721-bit instance plus a 32-bit instance
// where the last word is exactly full.
module tb_sc_bitstream_readback;
  localparam int unsigned BS  = 721;
  localparam int unsigned BS2 = 32;
  localparam int unsigned WW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_bitstream_readback_if #(.BITSTREAM_SIZE(BS),  .WORD_WIDTH(WW)) bus ();
  sc_bitstream_readback_if #(.BITSTREAM_SIZE(BS2), .WORD_WIDTH(WW)) bus32 ();

  sc_bitstream_readback #(.BITSTREAM_SIZE(BS), .WORD_WIDTH(WW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sc_bitstream_readback #(.BITSTREAM_SIZE(BS2), .WORD_WIDTH(WW)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  typedef struct {
    int          pat;
    int          addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vt [10];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pattern 0: alternating starting with 1, expected = same; pattern 1: ones for bits 0..63, exp 0
  function automatic logic pat_bit(input int pat, input int k);
    if (pat == 0) return (k % 2) == 0;
    return k < 64;
  endfunction

  function automatic logic pat_exp(input int pat, input int k);
    if (pat == 0) return (k % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_word(input int pat, input int w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (w * 16 + b < int'(BS)) r[b] = pat_bit(pat, w * 16 + b);
    end
    return r;
  endfunction

  task automatic drive(input int pat);
    bus.chain_tail = pat_bit(pat, int'(bus.bit_index));
    bus.exp_bit    = pat_exp(pat, int'(bus.bit_index));
  endtask

  task automatic rd(input int addr, input logic [15:0] exp, input string name);
    bus.rd_addr = 6'(addr);
    step();
    check(name, 32'(bus.rd_data), 32'(exp));
  endtask

  // Runs until DONE; optionally pulses start at bit poke_at to prove it is ignored.
  task automatic run(input int pat, input bit do_start, input int poke_at,
                     output int n_shift, output int gap);
    int  cyc;
    int  last_shift;
    int  done_cyc;
    bit  poked;
    cyc        = 0;
    last_shift = -100;
    done_cyc   = -1;
    n_shift    = 0;
    poked      = 1'b0;
    if (do_start) begin
      bus.start = 1'b1;
      step();
    end
    bus.start = 1'b0;
    while (cyc < 3000) begin
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.shift_en) begin
        n_shift++;
        last_shift = cyc;
      end
      bus.start = 1'b0;
      if (!poked && bus.shift_en && int'(bus.bit_index) == poke_at) begin
        bus.start = 1'b1;
        poked     = 1'b1;
        drive(pat);
        step();
        cyc++;
        bus.start = 1'b0;
        check("start_ignored_index", 32'(bus.bit_index), 32'(poke_at + 1));
        continue;
      end
      drive(pat);
      step();
      cyc++;
    end
    if (done_cyc < 0) begin
      check("run_timeout", 32'(0), 32'(1));
      gap = -1;
    end else begin
      gap = done_cyc - last_shift;
    end
  endtask

  initial begin
    int n_shift;
    int gap;
    int cyc;

    vt[0] = '{0, 0,  16'h5555};
    vt[1] = '{0, 1,  16'h5555};
    vt[2] = '{0, 44, 16'h5555};
    vt[3] = '{0, 45, 16'h0001};
    vt[4] = '{0, 50, 16'h0000};
    vt[5] = '{1, 0,  16'hFFFF};
    vt[6] = '{1, 3,  16'hFFFF};
    vt[7] = '{1, 4,  16'h0000};
    vt[8] = '{1, 45, 16'h0000};
    vt[9] = '{1, 50, 16'h0000};

    bus.start = 1'b0; bus.chain_tail = 1'b0; bus.exp_bit = 1'b0; bus.rd_addr = '0;
    bus32.start = 1'b0; bus32.chain_tail = 1'b1; bus32.exp_bit = 1'b1; bus32.rd_addr = '0;
    #1;
    step();
    step();
    check("rst_shift_en",  32'(bus.shift_en),       32'(0));
    check("rst_bit_index", 32'(bus.bit_index),      32'(0));
    check("rst_busy",      32'(bus.busy),           32'(0));
    check("rst_done",      32'(bus.done),           32'(0));
    check("rst_mismatch",  32'(bus.mismatch_count), 32'(0));
    check("rst_rd_data",   32'(bus.rd_data),        32'(0));
    rst_n = 1'b1;
    step();

    // Table-driven runs for both patterns
    for (int p = 0; p < 2; p++) begin
      run(p, 1'b1, -1, n_shift, gap);
      check("shift_cycles", 32'(n_shift), 32'(BS));
      check("done_gap", 32'(gap), 32'(2));
      check("mismatch", 32'(bus.mismatch_count), (p == 0) ? 32'(0) : 32'(64));
      check("done_bit_index", 32'(bus.bit_index), 32'(BS - 1));
      check("done_busy", 32'(bus.busy), 32'(0));
      for (int i = 0; i < 10; i++) begin
        if (vt[i].pat == p) rd(vt[i].addr, vt[i].exp, "table_word");
      end
      for (int w = 0; w < 46; w++) rd(w, model_word(p, w), "model_word");
      if (p == 0) begin
        bus.rd_addr = 6'd0;
        step();
        bus.rd_addr = 6'd45;
        #1;
        check("rd_latency_old", 32'(bus.rd_data), 32'(16'h5555));
        step();
        check("rd_latency_new", 32'(bus.rd_data), 32'(16'h0001));
      end
    end

    // 32-bit instance: last word full, FLUSH must not overwrite
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    n_shift = 0;
    cyc = 0;
    gap = -100;
    while (!bus32.done && cyc < 200) begin
      if (bus32.shift_en) begin
        n_shift++;
        gap = 0;
      end else begin
        gap++;
      end
      step();
      cyc++;
    end
    gap++;
    check("s32_done", 32'(bus32.done), 32'(1));
    check("s32_shift_cycles", 32'(n_shift), 32'(BS2));
    check("s32_done_gap", 32'(gap), 32'(2));
    check("s32_mismatch", 32'(bus32.mismatch_count), 32'(0));
    bus32.rd_addr = 1'b0;
    step();
    check("s32_word0", 32'(bus32.rd_data), 32'(16'hFFFF));
    bus32.rd_addr = 1'b1;
    step();
    check("s32_word1", 32'(bus32.rd_data), 32'(16'hFFFF));

    // Reset at bit 300 of an alternating run over the pattern-1 buffer
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (int'(bus.bit_index) != 300 && cyc < 1000) begin
      drive(0);
      step();
      cyc++;
    end
    check("abort_reached", 32'(bus.bit_index), 32'(300));
    rst_n = 1'b0;
    #1;
    check("abort_shift_en", 32'(bus.shift_en), 32'(0));
    check("abort_busy",     32'(bus.busy),     32'(0));
    check("abort_done",     32'(bus.done),     32'(0));
    step();
    rst_n = 1'b1;
    step();
    check("abort_idle_done", 32'(bus.done), 32'(0));
    check("abort_bit_index", 32'(bus.bit_index), 32'(0));
    for (int w = 0; w < 18; w++) rd(w, 16'h5555, "abort_new_word");
    rd(18, 16'h0000, "abort_unwritten_word");
    run(0, 1'b1, -1, n_shift, gap);
    check("rerun_shift_cycles", 32'(n_shift), 32'(BS));
    check("rerun_done_gap", 32'(gap), 32'(2));
    rd(45, 16'h0001, "rerun_last_word");

    // start ignored mid-run, then held in DONE for a back-to-back run
    run(1, 1'b1, 100, n_shift, gap);
    check("poke_shift_cycles", 32'(n_shift), 32'(BS));
    check("poke_mismatch", 32'(bus.mismatch_count), 32'(64));
    bus.start = 1'b1;
    step();
    check("b2b_shift_en", 32'(bus.shift_en), 32'(1));
    check("b2b_bit_index", 32'(bus.bit_index), 32'(0));
    check("b2b_mismatch_cleared", 32'(bus.mismatch_count), 32'(0));
    check("b2b_done", 32'(bus.done), 32'(0));
    run(1, 1'b0, -1, n_shift, gap);
    check("b2b_shift_cycles", 32'(n_shift), 32'(BS));
    check("b2b_mismatch", 32'(bus.mismatch_count), 32'(64));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
